// File: rtl/rv32_mod_instruction_prefetch.sv
// Prefetching instruction fetch unit: word FIFO, parcel realignment and one instruction per cycle to decode.
// Optional feature macro: RV32_PREFETCH_COMPRESSED_EN (16-bit parcel support); undefined = 32-bit words only.
module rv32_mod_instruction_prefetch #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        instr_req,
   input  logic        instr_ack,
   input  logic        instr_err,
   output logic [31:0] instr_addr,
   input  logic [31:0] instr_data_i,
   output logic        fetch_valid,
   input  logic        fetch_ready,
   output logic [31:0] fetch_instr,
   output logic [31:0] fetch_pc,
   output logic        fetch_is_compressed,
   output logic        fetch_err,
   input  logic        flush,
   input  logic [31:0] flush_pc
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
`ifdef RV32_PREFETCH_COMPRESSED_EN
   localparam logic [31:0] PC_MASK = 32'hFFFF_FFFE;
`else
   localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;
`endif

   logic [31:0]      mem_q [DEPTH];
   logic [DEPTH-1:0] werr_q;
   logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             req_q, req_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      tgt_q, tgt_d;
   logic [31:0]      pc_q, pc_d;
   logic             discard_q, discard_d;
   logic             err_stop_q, err_stop_d;

   logic             resp, push, consume, pop;
   logic [31:0]      head_w;
   logic             head_err, have_h;
   logic [31:0]      instr_w, pc_inc;
   logic             comp_w, valid_w, err_w, pop_w;

   assign resp     = req_q & (instr_ack | instr_err);
   assign push     = resp & ~discard_q & ~flush;
   assign head_w   = mem_q[rd_q];
   assign head_err = werr_q[rd_q];
   assign have_h   = (cnt_q != '0);

`ifdef RV32_PREFETCH_COMPRESSED_EN
   logic [15:0] parcel, next_lo;
   logic        next_err, have_n;

   assign next_lo  = mem_q[rd_q + AW'(1)][15:0];
   assign next_err = werr_q[rd_q + AW'(1)];
   assign have_n   = (cnt_q >= CW'(2));

   always_comb begin
      parcel  = pc_q[1] ? head_w[31:16] : head_w[15:0];
      comp_w  = (parcel[1:0] != 2'b11);
      instr_w = head_w;
      valid_w = have_h;
      err_w   = head_err;
      if (comp_w) begin
         instr_w = {16'h0000, parcel};
      end else if (pc_q[1]) begin
         // Straddling instruction: an errored head is presented alone so the trap is not stuck behind N.
         instr_w = {next_lo, head_w[31:16]};
         valid_w = have_n | (have_h & head_err);
         err_w   = head_err | (have_n & next_err);
      end
      pop_w  = pc_q[1] | ~comp_w;
      pc_inc = comp_w ? 32'd2 : 32'd4;
   end
`else
   always_comb begin
      instr_w = head_w;
      comp_w  = 1'b0;
      valid_w = have_h;
      err_w   = head_err;
      pop_w   = 1'b1;
      pc_inc  = 32'd4;
   end
`endif

   assign consume = valid_w & fetch_ready & ~flush;
   assign pop     = consume & pop_w;

   always_comb begin
      rd_d       = rd_q;
      wr_d       = wr_q;
      cnt_d      = cnt_q;
      pc_d       = pc_q;
      addr_d     = addr_q;
      tgt_d      = tgt_q;
      discard_d  = discard_q;
      err_stop_d = err_stop_q;
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
      if (consume) pc_d = pc_q + pc_inc;
      if (push && instr_err) err_stop_d = 1'b1;
      if (resp) begin
         addr_d    = discard_q ? tgt_q : addr_q + 32'd4;
         discard_d = 1'b0;
      end
      if (flush) begin
         rd_d       = '0;
         wr_d       = '0;
         cnt_d      = '0;
         pc_d       = flush_pc & PC_MASK;
         err_stop_d = 1'b0;
         // An unanswered request must complete on the old address; its response is thrown away.
         if (req_q && !resp) begin
            discard_d = 1'b1;
            tgt_d     = flush_pc & WORD_MASK;
         end else begin
            addr_d    = flush_pc & WORD_MASK;
            discard_d = 1'b0;
         end
      end
      if (req_q && !resp) req_d = 1'b1;
      else                req_d = ~err_stop_d & (cnt_d < FULL);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_q       <= '0;
         wr_q       <= '0;
         cnt_q      <= '0;
         req_q      <= 1'b0;
         addr_q     <= RESET_PC & WORD_MASK;
         tgt_q      <= RESET_PC & WORD_MASK;
         pc_q       <= RESET_PC & PC_MASK;
         discard_q  <= 1'b0;
         err_stop_q <= 1'b0;
      end else begin
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         cnt_q      <= cnt_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
         tgt_q      <= tgt_d;
         pc_q       <= pc_d;
         discard_q  <= discard_d;
         err_stop_q <= err_stop_d;
      end
   end

   // FIFO storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_q]  <= instr_data_i;
         werr_q[wr_q] <= instr_err;
      end
   end

   assign instr_req           = req_q;
   assign instr_addr          = addr_q;
   assign fetch_valid         = valid_w;
   assign fetch_instr         = instr_w;
   assign fetch_pc            = pc_q;
   assign fetch_is_compressed = comp_w;
   assign fetch_err           = valid_w & err_w;

endmodule

// File: tb/tb_rv32_mod_instruction_prefetch.sv
// Self-checking bench for rv32_mod_instruction_prefetch: vector table, directed corner sequences, random run.
module tb_rv32_mod_instruction_prefetch;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        instr_req, instr_ack, instr_err;
   logic [31:0] instr_addr, instr_data_i;
   logic        fetch_valid, fetch_ready;
   logic [31:0] fetch_instr, fetch_pc;
   logic        fetch_is_compressed, fetch_err;
   logic        flush;
   logic [31:0] flush_pc;

   always #5 clk = ~clk;

   rv32_mod_instruction_prefetch #(.DEPTH(4), .RESET_PC(32'h0)) dut (
      .clk(clk), .reset(reset),
      .instr_req(instr_req), .instr_ack(instr_ack), .instr_err(instr_err),
      .instr_addr(instr_addr), .instr_data_i(instr_data_i),
      .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_instr(fetch_instr),
      .fetch_pc(fetch_pc), .fetch_is_compressed(fetch_is_compressed), .fetch_err(fetch_err),
      .flush(flush), .flush_pc(flush_pc)
   );

`ifdef RV32_PREFETCH_COMPRESSED_EN
   localparam logic [31:0] PCM = 32'hFFFF_FFFE;
`else
   localparam logic [31:0] PCM = 32'hFFFF_FFFC;
`endif

   logic [31:0] mem [512];
   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic        ack;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc;
   } vec_t;
   vec_t tbl [6];

   task automatic chk1(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] parcel_at(input logic [31:0] a);
      logic [31:0] w;
      w = mem[a[10:2]];
      return a[1] ? w[31:16] : w[15:0];
   endfunction

   // Instruction expected at pc, derived from the memory image alone.
   function automatic void model(input logic [31:0] pc, output logic [31:0] ins,
                                 output logic comp, output logic [31:0] len);
`ifdef RV32_PREFETCH_COMPRESSED_EN
      logic [15:0] lo;
      lo = parcel_at(pc);
      if (lo[1:0] != 2'b11) begin
         ins = {16'h0, lo}; comp = 1'b1; len = 32'd2;
      end else begin
         ins = {parcel_at(pc + 32'd2), lo}; comp = 1'b0; len = 32'd4;
      end
`else
      ins = mem[pc[10:2]]; comp = 1'b0; len = 32'd4;
`endif
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk1("reset_drops_req", instr_req, 1'b0);
      instr_ack = 0; instr_err = 0; flush = 0; flush_pc = 0; fetch_ready = 0; instr_data_i = 0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic fill_pattern();
      for (int i = 0; i < 512; i++) mem[i] = (32'(i) << 20) | 32'h13;
   endtask

   // Ack every request except one at stop_addr; stop once that request is pending.
   task automatic run_to_addr(input logic [31:0] stop_addr);
      int c;
      c = 0;
      while (!(instr_req && instr_addr == stop_addr) && c < 20) begin
         instr_ack = instr_req;
         instr_data_i = mem[instr_addr[10:2]];
         @(negedge clk);
         c++;
      end
      instr_ack = 0;
      chk1("reach_req", instr_req, 1'b1);
      chk32("reach_addr", instr_addr, stop_addr);
   endtask

   task automatic discard_test(input logic [31:0] f1, input bit twice, input logic [31:0] f2);
      logic [31:0] ei, el, tgt;
      logic ec;
      do_reset();
      fetch_ready = 0;
      run_to_addr(32'h8);
      flush = 1; flush_pc = f1;
      @(negedge clk);
      flush = 0;
      tgt = f1;
      chk1("dis_req_held", instr_req, 1'b1);
      chk32("dis_addr_held", instr_addr, 32'h8);
      chk1("dis_empty", fetch_valid, 1'b0);
      chk32("dis_pc", fetch_pc, f1 & PCM);
      if (twice) begin
         flush = 1; flush_pc = f2;
         @(negedge clk);
         flush = 0;
         tgt = f2;
         chk32("dis2_addr_held", instr_addr, 32'h8);
         chk32("dis2_pc", fetch_pc, f2 & PCM);
      end
      instr_ack = 1; instr_data_i = mem[2];
      @(negedge clk);
      instr_ack = 0;
      chk1("dis_dropped", fetch_valid, 1'b0);
      chk1("dis_new_req", instr_req, 1'b1);
      chk32("dis_new_addr", instr_addr, tgt & 32'hFFFF_FFFC);
      instr_ack = 1; instr_data_i = mem[instr_addr[10:2]];
      @(negedge clk);
      instr_ack = 0;
      model(tgt & PCM, ei, ec, el);
      chk1("dis_valid", fetch_valid, 1'b1);
      chk32("dis_first_pc", fetch_pc, tgt & PCM);
      chk32("dis_first_instr", fetch_instr, ei);
   endtask

   initial begin
      logic [31:0] ei, el, exp_pc, pend_addr;
      logic ec, pend, seen_a, seen_b, err_sent;
      int acks, consumes, dly;

      instr_ack = 0; instr_err = 0; flush = 0; flush_pc = 0; fetch_ready = 0; instr_data_i = 0;

      // Streaming after reset, one-cycle acks, decoder always ready.
      tbl[0] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
      tbl[1] = '{1'b1, 1'b1, 32'h0, 1'b0, 32'h0};
      tbl[2] = '{1'b1, 1'b1, 32'h4, 1'b1, 32'h0};
      tbl[3] = '{1'b1, 1'b1, 32'h8, 1'b1, 32'h4};
      tbl[4] = '{1'b0, 1'b1, 32'hC, 1'b1, 32'h8};
      tbl[5] = '{1'b0, 1'b1, 32'hC, 1'b0, 32'hC};
      for (int i = 0; i < 512; i++) mem[i] = 32'h0000_0013;
      do_reset();
      chk1("reset_err", fetch_err, 1'b0);
      fetch_ready = 1;
      for (int i = 0; i < 6; i++) begin
         chk1("tbl_req", instr_req, tbl[i].exp_req);
         chk32("tbl_addr", instr_addr, tbl[i].exp_addr);
         chk1("tbl_valid", fetch_valid, tbl[i].exp_valid);
         chk32("tbl_pc", fetch_pc, tbl[i].exp_pc);
         if (tbl[i].exp_valid) chk32("tbl_instr", fetch_instr, 32'h13);
         instr_ack = tbl[i].ack;
         instr_data_i = mem[instr_addr[10:2]];
         @(negedge clk);
      end
      instr_ack = 0;

      // Decoder stalled: FIFO fills to DEPTH and the bus goes quiet.
      do_reset();
      fetch_ready = 0;
      acks = 0;
      for (int c = 0; c < 12; c++) begin
         instr_ack = instr_req;
         if (instr_req) acks++;
         instr_data_i = mem[instr_addr[10:2]];
         @(negedge clk);
      end
      instr_ack = 0;
      chk32("full_acks", 32'(acks), 32'd4);
      chk1("full_req_low", instr_req, 1'b0);
      chk32("full_pc", fetch_pc, 32'h0);
      fetch_ready = 1;
      @(negedge clk);
      fetch_ready = 0;
      chk1("full_req_resume", instr_req, 1'b1);
      chk32("full_pc_next", fetch_pc, 32'h4);

      // Parcel realignment (or plain words when compressed support is off).
      for (int i = 0; i < 512; i++) mem[i] = 32'h0000_0013;
      mem[0] = 32'h0013_4501;
      mem[1] = 32'h0000_0001;
      do_reset();
      fetch_ready = 1;
      seen_a = 0; seen_b = 0;
      for (int c = 0; c < 12; c++) begin
         if (fetch_valid && fetch_pc == 32'h0) begin
            seen_a = 1;
`ifdef RV32_PREFETCH_COMPRESSED_EN
            chk32("c_pc0_instr", fetch_instr, 32'h0000_4501);
            chk1("c_pc0_comp", fetch_is_compressed, 1'b1);
`else
            chk32("w_pc0_instr", fetch_instr, 32'h0013_4501);
            chk1("w_pc0_comp", fetch_is_compressed, 1'b0);
`endif
         end
`ifdef RV32_PREFETCH_COMPRESSED_EN
         if (fetch_valid && fetch_pc == 32'h2) begin
            seen_b = 1;
            chk32("c_pc2_instr", fetch_instr, 32'h0001_0013);
            chk1("c_pc2_comp", fetch_is_compressed, 1'b0);
         end
`else
         if (fetch_valid && fetch_pc == 32'h4) begin
            seen_b = 1;
            chk32("w_pc4_instr", fetch_instr, 32'h0000_0001);
         end
`endif
         instr_ack = instr_req;
         instr_data_i = mem[instr_addr[10:2]];
         @(negedge clk);
      end
      instr_ack = 0;
      chk1("parcel_seen_first", seen_a, 1'b1);
      chk1("parcel_seen_second", seen_b, 1'b1);

      // Flush while a request is outstanding, once and twice.
      fill_pattern();
      discard_test(32'h102, 1'b0, 32'h0);
      discard_test(32'h102, 1'b1, 32'h182);

      // Bus error on word 0x4.
      for (int i = 0; i < 512; i++) mem[i] = 32'h0000_0013;
      do_reset();
      fetch_ready = 1;
      seen_a = 0; err_sent = 0;
      for (int c = 0; c < 14; c++) begin
         if (err_sent) chk1("err_stop_no_req", instr_req, 1'b0);
         if (fetch_valid) begin
            chk1("err_flag", fetch_err, fetch_pc == 32'h4);
            if (fetch_pc == 32'h4) seen_a = 1;
         end
         instr_ack = 0; instr_err = 0;
         if (instr_req) begin
            if (instr_addr == 32'h4) begin instr_err = 1; err_sent = 1; end
            else instr_ack = 1;
         end
         instr_data_i = mem[instr_addr[10:2]];
         @(negedge clk);
      end
      instr_ack = 0; instr_err = 0;
      chk1("err_seen_valid", seen_a, 1'b1);
      flush = 1; flush_pc = 32'h200;
      @(negedge clk);
      flush = 0;
      chk1("err_flush_req", instr_req, 1'b1);
      chk32("err_flush_addr", instr_addr, 32'h200);
      chk1("err_flush_clear", fetch_err, 1'b0);

      // Flush coinciding with an ack.
      fill_pattern();
      do_reset();
      fetch_ready = 0;
      run_to_addr(32'h8);
      instr_ack = 1; instr_data_i = mem[2]; flush = 1; flush_pc = 32'h300;
      @(negedge clk);
      instr_ack = 0; flush = 0;
      chk1("fa_empty", fetch_valid, 1'b0);
      chk1("fa_req", instr_req, 1'b1);
      chk32("fa_addr", instr_addr, 32'h300);
      instr_ack = 1; instr_data_i = mem[instr_addr[10:2]];
      @(negedge clk);
      instr_ack = 0;
      model(32'h300, ei, ec, el);
      chk1("fa_valid", fetch_valid, 1'b1);
      chk32("fa_pc", fetch_pc, 32'h300);
      chk32("fa_instr", fetch_instr, ei);

      // Random traffic against the memory-image model.
      for (int i = 0; i < 512; i++) mem[i] = $urandom;
      do_reset();
      exp_pc = 32'h0; pend = 0; pend_addr = 0; consumes = 0; dly = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (pend) begin
            chk1("rnd_req_hold", instr_req, 1'b1);
            chk32("rnd_addr_hold", instr_addr, pend_addr);
         end
         fetch_ready = ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 49) == 0);
         flush_pc = 32'($urandom_range(0, 2047));
         if (flush) begin
            exp_pc = flush_pc & PCM;
         end else if (fetch_valid && fetch_ready) begin
            model(exp_pc, ei, ec, el);
            chk32("rnd_pc", fetch_pc, exp_pc);
            chk32("rnd_instr", fetch_instr, ei);
            chk1("rnd_comp", fetch_is_compressed, ec);
            chk1("rnd_err", fetch_err, 1'b0);
            exp_pc = exp_pc + el;
            consumes++;
         end
         instr_ack = 0;
         if (instr_req) begin
            if (dly == 0) begin
               instr_ack = 1;
               instr_data_i = mem[instr_addr[10:2]];
               dly = $urandom_range(0, 2);
            end else begin
               dly--;
            end
         end
         pend = instr_req && !instr_ack;
         pend_addr = instr_addr;
         @(negedge clk);
      end
      instr_ack = 0; flush = 0;
      chk1("rnd_progress", consumes > 100, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
